// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multi-cycle MIPS core: opcodes, FSM state
// encodings and instruction field positions.
package mips_mc_pkg;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_ADDI = 4'd7;
    localparam logic [3:0] OP_BEQ  = 4'd8;
    localparam logic [3:0] OP_BNE  = 4'd9;
    localparam logic [3:0] OP_J    = 4'd10;
    localparam logic [3:0] OP_HALT = 4'd15;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_WB     = 3'd3;
    localparam logic [2:0] S_HALT   = 3'd4;

    localparam int unsigned OP_MSB  = 31;
    localparam int unsigned OP_LSB  = 28;
    localparam int unsigned RD_LSB  = 23;
    localparam int unsigned RS_LSB  = 18;
    localparam int unsigned RT_LSB  = 13;
    localparam int unsigned IMM_MSB = 12;
    localparam int unsigned IMM_LSB = 0;

    // Register-writing operations (ADD..ADDI) go through the WB state.
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_ADDI);
    endfunction

    function automatic logic is_illegal_op(input logic [3:0] op);
        return (op >= 4'd11) && (op <= 4'd14);
    endfunction

endpackage

// File: rtl/mips_mc_alu.sv
// Combinational ALU; branches reuse the subtractor and consume the zero flag.
module mips_mc_alu
    import mips_mc_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    always_comb begin
        result = '0;
        case (op)
            OP_ADD, OP_ADDI:         result = a + b;
            OP_SUB, OP_BEQ, OP_BNE:  result = a - b;
            OP_AND:                  result = a & b;
            OP_OR:                   result = a | b;
            OP_XOR:                  result = a ^ b;
            OP_SLT:                  result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            default:                 result = '0;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/mips_multi_cycle_core.sv
// Multi-cycle MIPS-style core: FETCH/DECODE/EXEC/WB FSM over a loadable
// instruction memory and a reset-cleared register file.
module mips_multi_cycle_core
    import mips_mc_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned NUM_REGS   = 32,
    parameter int unsigned IMEM_DEPTH = 64,
    localparam int unsigned PC_W      = $clog2(IMEM_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              imem_we,
    input  logic [PC_W-1:0]   imem_waddr,
    input  logic [31:0]       imem_wdata,
    output logic [DATA_W-1:0] alu_res,
    output logic [PC_W-1:0]   pc,
    output logic              retire,
    output logic              halted,
    output logic              illegal
);

    localparam int unsigned REG_AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [2:0]        state;
    logic [31:0]       ir;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] res_q;
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] imm_ext;
    logic              alu_zero;
    logic [3:0]        op;
    logic [REG_AW-1:0] rd_idx;
    logic [REG_AW-1:0] rs_idx;
    logic [REG_AW-1:0] rt_idx;
    logic [PC_W-1:0]   pc_inc;
    logic [PC_W-1:0]   br_target;
    logic              br_taken;

    logic [31:0]       imem [IMEM_DEPTH];
    logic [DATA_W-1:0] regs [NUM_REGS];

    assign op      = ir[OP_MSB:OP_LSB];
    assign rd_idx  = ir[RD_LSB +: REG_AW];
    assign rs_idx  = ir[RS_LSB +: REG_AW];
    assign rt_idx  = ir[RT_LSB +: REG_AW];
    assign imm_ext = {{(DATA_W-13){ir[IMM_MSB]}}, ir[IMM_MSB:IMM_LSB]};

    // Offset truncated to PC width; the add wraps modulo IMEM_DEPTH.
    assign pc_inc    = pc + PC_W'(1);
    assign br_target = pc_inc + ir[PC_W-1:0];
    assign br_taken  = (op == OP_BEQ) ? alu_zero : !alu_zero;
    assign halted    = (state == S_HALT);

    mips_mc_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (op),
        .a      (a_q),
        .b      (b_q),
        .result (alu_out),
        .zero   (alu_zero)
    );

    // Program memory survives reset so a loaded image can be rerun.
    always_ff @(posedge clk) begin
        if (imem_we)
            imem[imem_waddr] <= imem_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset)
            regs <= '{default: '0};
        else if (enable && (state == S_WB) && (rd_idx != '0))
            regs[rd_idx] <= res_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_FETCH;
            pc      <= '0;
            alu_res <= '0;
            retire  <= 1'b0;
            illegal <= 1'b0;
            ir      <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            retire <= 1'b0;
            if (enable) begin
                case (state)
                    S_FETCH: begin
                        ir    <= imem[pc];
                        state <= S_DECODE;
                    end
                    S_DECODE: begin
                        a_q   <= regs[rs_idx];
                        b_q   <= (op == OP_ADDI) ? imm_ext : regs[rt_idx];
                        state <= S_EXEC;
                    end
                    S_EXEC: begin
                        if (is_alu_op(op)) begin
                            res_q <= alu_out;
                            state <= S_WB;
                        end else if (op == OP_HALT) begin
                            retire <= 1'b1;
                            state  <= S_HALT;
                        end else begin
                            retire <= 1'b1;
                            state  <= S_FETCH;
                            if ((op == OP_BEQ) || (op == OP_BNE))
                                pc <= br_taken ? br_target : pc_inc;
                            else if (op == OP_J)
                                pc <= ir[PC_W-1:0];
                            else
                                pc <= pc_inc;
                            if (is_illegal_op(op))
                                illegal <= 1'b1;
                        end
                    end
                    S_WB: begin
                        alu_res <= res_q;
                        pc      <= pc_inc;
                        retire  <= 1'b1;
                        state   <= S_FETCH;
                    end
                    S_HALT: state <= S_HALT;
                    default: state <= S_FETCH;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mips_multi_cycle_core.sv
// Scoreboard bench: an ISA-level interpreter predicts every retirement of two
// core instances (32-bit/64-word and 16-bit/16-word); monitors check on retire.
module tb_mips_multi_cycle_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst;
    logic [1:0]       en;
    logic [1:0]       we;
    logic [1:0][5:0]  wa;
    logic [1:0][31:0] wd;
    logic [1:0]       ret;
    logic [1:0]       hlt;
    logic [1:0]       ill;
    logic [31:0]      alu0;
    logic [15:0]      alu1;
    logic [5:0]       pc0;
    logic [3:0]       pc1;

    mips_multi_cycle_core #(.DATA_W(32), .NUM_REGS(32), .IMEM_DEPTH(64)) dut0 (
        .clk(clk), .reset(rst[0]), .enable(en[0]), .imem_we(we[0]),
        .imem_waddr(wa[0]), .imem_wdata(wd[0]), .alu_res(alu0), .pc(pc0),
        .retire(ret[0]), .halted(hlt[0]), .illegal(ill[0])
    );

    mips_multi_cycle_core #(.DATA_W(16), .NUM_REGS(16), .IMEM_DEPTH(16)) dut1 (
        .clk(clk), .reset(rst[1]), .enable(en[1]), .imem_we(we[1]),
        .imem_waddr(wa[1][3:0]), .imem_wdata(wd[1]), .alu_res(alu1), .pc(pc1),
        .retire(ret[1]), .halted(hlt[1]), .illegal(ill[1])
    );

    typedef struct {
        longint unsigned pc;
        longint unsigned alu;
        bit              hlt;
        bit              ill;
        int              cyc;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    int          raw_log0[$];
    int          checks = 0;
    int          errors = 0;
    int          raw_c[2];
    int          en_c[2];
    logic [31:0] prog [64];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] cur_pc(input int which);
        return (which == 0) ? 64'(pc0) : 64'(pc1);
    endfunction

    function automatic logic [63:0] cur_alu(input int which);
        return (which == 0) ? 64'(alu0) : 64'(alu1);
    endfunction

    function automatic logic [31:0] enc(input logic [3:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [12:0] imm);
        return {op, rd, rs, rt, imm};
    endfunction

    task automatic clear_prog();
        foreach (prog[i]) prog[i] = 32'h0;
    endtask

    // Cycle counters relative to reset release: all cycles, and enabled cycles.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst[k]) begin
                raw_c[k] <= 0;
                en_c[k]  <= 0;
            end else begin
                raw_c[k] <= raw_c[k] + 1;
                if (en[k]) en_c[k] <= en_c[k] + 1;
            end
        end
    end

    task automatic mon_check(input int which);
        exp_t e;
        int   sz;
        sz = (which == 0) ? q0.size() : q1.size();
        if (sz == 0) begin
            checks++;
            errors++;
            $display("FAIL retire_unexpected%0d: got retire at pc %0d expected none", which, cur_pc(which));
        end else begin
            e = (which == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("pc%0d", which), cur_pc(which), e.pc);
            chk($sformatf("alu_res%0d", which), cur_alu(which), e.alu);
            chk($sformatf("halted%0d", which), 64'(hlt[which]), 64'(e.hlt));
            chk($sformatf("illegal%0d", which), 64'(ill[which]), 64'(e.ill));
            chk($sformatf("latency%0d", which), 64'(en_c[which]), 64'(e.cyc));
        end
    endtask

    always @(negedge clk) begin
        if (!rst[0] && ret[0]) begin
            mon_check(0);
            raw_log0.push_back(raw_c[0]);
        end
    end

    always @(negedge clk) begin
        if (!rst[1] && ret[1]) mon_check(1);
    end

    // Instruction-set interpreter: predicts state after every retirement and
    // the enabled-cycle count at which it becomes visible.
    task automatic model(input int which, input int dw, input int pcw, input int rw);
        longint unsigned r[32];
        longint unsigned dm, sb, a, b, v, immx, alu;
        int              pc, cyc, depth, op, rd, rs, rt, rmask;
        bit              ill_f, done, taken;
        logic [31:0]     ins;
        exp_t            e;
        dm    = (64'd1 << dw) - 64'd1;
        sb    = 64'd1 << (dw - 1);
        depth = 1 << pcw;
        rmask = (1 << rw) - 1;
        foreach (r[i]) r[i] = 0;
        pc = 0; cyc = 0; alu = 0; ill_f = 0; done = 0;
        for (int s = 0; s < 400 && !done; s++) begin
            ins  = prog[pc];
            op   = int'(ins[31:28]);
            rd   = int'(ins[27:23]) & rmask;
            rs   = int'(ins[22:18]) & rmask;
            rt   = int'(ins[17:13]) & rmask;
            immx = {{51{ins[12]}}, ins[12:0]} & dm;
            if (op >= 1 && op <= 7) begin
                a = r[rs];
                b = (op == 7) ? immx : r[rt];
                case (op)
                    2:       v = a - b;
                    3:       v = a & b;
                    4:       v = a | b;
                    5:       v = a ^ b;
                    6:       v = ((a ^ sb) < (b ^ sb)) ? 64'd1 : 64'd0;
                    default: v = a + b;
                endcase
                v = v & dm;
                if (rd != 0) r[rd] = v;
                alu = v;
                pc  = (pc + 1) % depth;
                cyc += 4;
            end else begin
                cyc += 3;
                if (op == 8 || op == 9) begin
                    taken = ((r[rs] == r[rt]) == (op == 8));
                    pc = taken ? (pc + 1 + int'(ins[12:0])) % depth : (pc + 1) % depth;
                end else if (op == 10) begin
                    pc = int'(ins[12:0]) % depth;
                end else if (op == 15) begin
                    done = 1;
                end else begin
                    if (op != 0) ill_f = 1;
                    pc = (pc + 1) % depth;
                end
            end
            e.pc = longint'(pc); e.alu = alu; e.hlt = done; e.ill = ill_f; e.cyc = cyc;
            if (which == 0) q0.push_back(e);
            else q1.push_back(e);
        end
    endtask

    task automatic run(input int which, input int dw, input int pcw, input int rw,
                       input int stall_at, input int stall_len, input bit rnd_en);
        int          n;
        logic [63:0] frozen;
        int          sz;
        @(negedge clk);
        rst[which] = 1'b1;
        en[which]  = 1'b1;
        for (int i = 0; i < (1 << pcw); i++) begin
            @(negedge clk);
            we[which] = 1'b1;
            wa[which] = 6'(i);
            wd[which] = prog[i];
        end
        @(negedge clk);
        we[which] = 1'b0;
        chk("reset_pc", cur_pc(which), 64'd0);
        chk("reset_alu_res", cur_alu(which), 64'd0);
        chk("reset_retire", 64'(ret[which]), 64'd0);
        chk("reset_halted", 64'(hlt[which]), 64'd0);
        chk("reset_illegal", 64'(ill[which]), 64'd0);
        model(which, dw, pcw, rw);
        if (which == 0) raw_log0.delete();
        rst[which] = 1'b0;
        n = 0;
        frozen = '0;
        while (!hlt[which] && n < 3000) begin
            @(negedge clk);
            n++;
            if (rnd_en) begin
                en[which] = ($urandom_range(0, 3) != 0);
            end else if (stall_len > 0) begin
                if (n > stall_at && n <= stall_at + stall_len) begin
                    chk("stall_pc_frozen", cur_pc(which), frozen);
                    chk("stall_retire_low", 64'(ret[which]), 64'd0);
                end
                if (n == stall_at) frozen = cur_pc(which);
                en[which] = !(n >= stall_at && n < stall_at + stall_len);
            end
        end
        chk("halt_reached", 64'(hlt[which]), 64'd1);
        en[which] = 1'b1;
        repeat (3) @(negedge clk);
        sz = (which == 0) ? q0.size() : q1.size();
        chk("scoreboard_drained", 64'(sz), 64'd0);
        chk("halt_pc_hold", 64'(hlt[which]), 64'd1);
        if (which == 0) q0.delete();
        else q1.delete();
    endtask

    task automatic gen_random(input int len);
        clear_prog();
        for (int i = 0; i < len; i++) begin
            int         k;
            logic [4:0] rd, rs, rt;
            k  = $urandom_range(0, 9);
            rd = 5'($urandom_range(0, 7));
            rs = 5'($urandom_range(0, 7));
            rt = 5'($urandom_range(0, 7));
            case (k)
                0, 1, 2, 3: prog[i] = enc(4'($urandom_range(1, 6)), rd, rs, rt, 13'($urandom));
                4, 5:       prog[i] = enc(4'd7, rd, rs, rt, 13'($urandom));
                6:          prog[i] = enc(4'($urandom_range(8, 9)), rd, rs, rt, 13'($urandom_range(0, len - 1 - i)));
                7:          prog[i] = enc(4'd10, rd, rs, rt, 13'($urandom_range(i + 1, len)));
                8:          prog[i] = enc(4'd0, rd, rs, rt, 13'($urandom));
                default:    prog[i] = enc(4'($urandom_range(11, 14)), rd, rs, rt, 13'($urandom));
            endcase
        end
        prog[len] = enc(4'd15, 5'd0, 5'd0, 5'd0, 13'd0);
    endtask

    initial begin
        rst = '1; en = '1; we = '0; wa = '0; wd = '0;
        repeat (2) @(negedge clk);

        // Straight-line: retire at cycles 4, 8, 12, 15.
        clear_prog();
        prog[0] = enc(4'd7, 5'd1, 5'd0, 5'd0, 13'd5);
        prog[1] = enc(4'd7, 5'd2, 5'd0, 5'd0, 13'd7);
        prog[2] = enc(4'd1, 5'd3, 5'd1, 5'd2, 13'd0);
        prog[3] = enc(4'd15, 5'd0, 5'd0, 5'd0, 13'd0);
        run(0, 32, 6, 5, 0, 0, 1'b0);
        chk("prog1_alu_res", 64'(alu0), 64'd12);
        chk("prog1_pc", 64'(pc0), 64'd3);
        chk("prog1_retires", 64'(raw_log0.size()), 64'd4);
        if (raw_log0.size() == 4) begin
            chk("prog1_retire_cyc0", 64'(raw_log0[0]), 64'd4);
            chk("prog1_retire_cyc1", 64'(raw_log0[1]), 64'd8);
            chk("prog1_retire_cyc2", 64'(raw_log0[2]), 64'd12);
            chk("prog1_retire_cyc3", 64'(raw_log0[3]), 64'd15);
        end

        // Countdown loop with backward BNE.
        clear_prog();
        prog[0] = enc(4'd7, 5'd1, 5'd0, 5'd0, 13'd3);
        prog[1] = enc(4'd7, 5'd1, 5'd1, 5'd0, 13'h1FFF);
        prog[2] = enc(4'd9, 5'd0, 5'd1, 5'd0, 13'h1FFE);
        prog[3] = enc(4'd15, 5'd0, 5'd0, 5'd0, 13'd0);
        run(0, 32, 6, 5, 0, 0, 1'b0);
        chk("loop_alu_res", 64'(alu0), 64'd0);
        chk("loop_retires", 64'(raw_log0.size()), 64'd8);

        // r0 is never written.
        clear_prog();
        prog[0] = enc(4'd7, 5'd0, 5'd0, 5'd0, 13'd9);
        prog[1] = enc(4'd1, 5'd4, 5'd0, 5'd0, 13'd0);
        prog[2] = enc(4'd15, 5'd0, 5'd0, 5'd0, 13'd0);
        run(0, 32, 6, 5, 0, 0, 1'b0);
        chk("r0_alu_res", 64'(alu0), 64'd0);

        // Five-cycle stall while SUB sits in EXEC.
        clear_prog();
        prog[0] = enc(4'd7, 5'd1, 5'd0, 5'd0, 13'd3);
        prog[1] = enc(4'd7, 5'd2, 5'd0, 5'd0, 13'd10);
        prog[2] = enc(4'd2, 5'd5, 5'd1, 5'd2, 13'd0);
        prog[3] = enc(4'd15, 5'd0, 5'd0, 5'd0, 13'd0);
        run(0, 32, 6, 5, 10, 5, 1'b0);
        chk("stall_alu_res", 64'(alu0), 64'hFFFF_FFF9);
        if (raw_log0.size() >= 3) chk("stall_sub_retire_cyc", 64'(raw_log0[2]), 64'd17);
        else chk("stall_retire_count", 64'(raw_log0.size()), 64'd4);

        // Illegal opcode at pc 0; the next run's reset checks clear it.
        clear_prog();
        prog[0] = enc(4'd12, 5'd1, 5'd0, 5'd0, 13'd5);
        prog[1] = enc(4'd1, 5'd4, 5'd1, 5'd1, 13'd0);
        prog[2] = enc(4'd15, 5'd0, 5'd0, 5'd0, 13'd0);
        run(0, 32, 6, 5, 0, 0, 1'b0);
        chk("illegal_sticky", 64'(ill[0]), 64'd1);
        chk("illegal_no_write", 64'(alu0), 64'd0);

        // J to last word, wrap to pc 0.
        clear_prog();
        prog[0]  = enc(4'd9, 5'd0, 5'd1, 5'd0, 13'd1);
        prog[1]  = enc(4'd10, 5'd0, 5'd0, 5'd0, 13'd63);
        prog[2]  = enc(4'd15, 5'd0, 5'd0, 5'd0, 13'd0);
        prog[63] = enc(4'd7, 5'd1, 5'd0, 5'd0, 13'd1);
        run(0, 32, 6, 5, 0, 0, 1'b0);
        chk("wrap_alu_res", 64'(alu0), 64'd1);

        // Narrow instance: wrap plus signed SLT -1 < 1.
        clear_prog();
        prog[0]  = enc(4'd9, 5'd0, 5'd1, 5'd0, 13'd1);
        prog[1]  = enc(4'd10, 5'd0, 5'd0, 5'd0, 13'd15);
        prog[2]  = enc(4'd7, 5'd2, 5'd0, 5'd0, 13'h1FFF);
        prog[3]  = enc(4'd6, 5'd3, 5'd2, 5'd1, 13'd0);
        prog[4]  = enc(4'd15, 5'd0, 5'd0, 5'd0, 13'd0);
        prog[15] = enc(4'd7, 5'd1, 5'd0, 5'd0, 13'd1);
        run(1, 16, 4, 4, 0, 0, 1'b0);
        chk("narrow_slt", 64'(alu1), 64'd1);
        chk("narrow_pc", 64'(pc1), 64'd4);

        // Random forward-only programs, half with random enable.
        for (int t = 0; t < 8; t++) begin
            gen_random(20 + (t * 3));
            run(0, 32, 6, 5, 0, 0, t[0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
